// File: rtl/mac_pkg.sv
// Shared MAC definitions: mode encodings, result width and the tagged result record.
package mac_pkg;

    localparam logic MODE_SUMP = 1'b0;
    localparam logic MODE_TRI  = 1'b1;

    localparam int MAC_DATA_W = 17;

    typedef struct packed {
        logic                  mode;
        logic [MAC_DATA_W-1:0] data;
    } mac_result_t;

endpackage

// File: rtl/mac_result_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty disambiguation.
// Latency: a push at edge N is visible at pop_data after edge N; no bypass.
// Backpressure: none internal; the caller must not push when full unless popping.
module mac_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/mac_result_collector.sv
// Buffers mode-tagged MAC results for a valid/ready consumer; counts drops; MAC_COLLECT_SUM_EN adds a running sum.
// Latency: one cycle from valid_output to res_valid, no combinational input-to-output path.
// Backpressure: when full and not popping, the incoming result is dropped and recorded in overflow/drop_cnt.
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    parameter int SUM_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_output,
    input  logic [DATA_W-1:0]        final_output,
    input  logic                     mode,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W:0]          res_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clear_stats,
    output logic [SUM_W-1:0]         sum_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            drop;
    logic [DATA_W:0] head;
    logic [DATA_W:0] last;

    assign res_valid = !empty;
    assign pop       = res_valid && res_ready;
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign push      = valid_output && (!full || pop);
    assign drop      = valid_output && full && !pop;

    mac_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({mode, final_output}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Remember the last delivered entry so res_data holds while empty.
    always_ff @(posedge clk) begin
        if (reset)    last <= '0;
        else if (pop) last <= head;
    end

    assign res_data = empty ? last : head;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_stats)    drop_cnt <= CNT_ONE;
            else if (!(&drop_cnt)) drop_cnt <= drop_cnt + CNT_ONE;
        end else if (clear_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef MAC_COLLECT_SUM_EN
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_base;
    logic [SUM_W:0]   sum_wide;
    logic [SUM_W-1:0] sum_next;

    always_comb begin
        sum_base = clear_stats ? '0 : sum_q;
        sum_wide = {1'b0, sum_base} + (SUM_W+1)'(final_output);
        sum_next = sum_base;
        if (push) sum_next = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_next;
    end

    assign sum_out = sum_q;
`else
    assign sum_out = '0;
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed-vector bench for mac_result_collector: reset, latency, ordering, full/drop, stats clear, reset flush.
module tb_mac_result_collector;
    import mac_pkg::*;

    localparam int DW = MAC_DATA_W;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           valid_output = 1'b0;
    logic [DW-1:0]  final_output = '0;
    logic           mode = 1'b0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [DW:0]    res_data;
    logic [3:0]     level;
    logic           overflow;
    logic [7:0]     drop_cnt;
    logic           clear_stats = 1'b0;
    logic [23:0]    sum_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mac_result_collector #(
        .DATA_W (DW),
        .DEPTH  (8),
        .CNT_W  (8),
        .SUM_W  (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_output (valid_output),
        .final_output (final_output),
        .mode         (mode),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clear_stats  (clear_stats),
        .sum_out      (sum_out)
    );

    always #5 clk = ~clk;

    function automatic mac_result_t mk(input logic m, input int d);
        mac_result_t r;
        r.mode = m;
        r.data = DW'(d);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int n);
        res_ready    = 1'b0;
        valid_output = 1'b1;
        for (int i = 0; i < n; i++) begin
            final_output = DW'(base + i);
            mode         = i[0];
            step();
        end
        valid_output = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        n_cmp++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data got %h want 0", res_data); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        n_cmp++; if (sum_out !== 24'd0) begin n_fail++; $display("FAIL reset_sum_out got %0d want 0", sum_out); end
    endtask

    task automatic test_single_tri();
        valid_output = 1'b1; mode = MODE_TRI; final_output = DW'(52);
        step();
        valid_output = 1'b0; mode = MODE_SUMP; final_output = DW'(7);
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== mk(MODE_TRI, 52)) begin n_fail++; $display("FAIL single_data got %h want %h", res_data, mk(MODE_TRI, 52)); end
        n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        res_ready = 1'b1;
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %0b want 0", res_valid); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_pop_level got %0d want 0", level); end
        n_cmp++; if (res_data !== mk(MODE_TRI, 52)) begin n_fail++; $display("FAIL single_hold_data got %h want %h", res_data, mk(MODE_TRI, 52)); end
        step();
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL empty_pop_level got %0d want 0", level); end
        // push and pop together while empty: push only
        valid_output = 1'b1; mode = MODE_SUMP; final_output = DW'(9);
        step();
        valid_output = 1'b0;
        n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL empty_pushpop_level got %0d want 1", level); end
        n_cmp++; if (res_data !== mk(MODE_SUMP, 9)) begin n_fail++; $display("FAIL empty_pushpop_data got %h want %h", res_data, mk(MODE_SUMP, 9)); end
        step();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop_drain got %0b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        mac_result_t exp [3];
        exp[0] = mk(MODE_TRI, 638);
        exp[1] = mk(MODE_SUMP, 15);
        exp[2] = mk(MODE_SUMP, 72);
        res_ready = 1'b0;
        valid_output = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode = exp[i].mode; final_output = exp[i].data;
            step();
        end
        valid_output = 1'b0;
        n_cmp++; if (level !== 4'd3) begin n_fail++; $display("FAIL b2b_level got %0d want 3", level); end
        step();
        n_cmp++; if (res_data !== exp[0]) begin n_fail++; $display("FAIL b2b_stall_hold got %h want %h", res_data, exp[0]); end
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (res_valid !== 1'b1 || res_data !== exp[i]) begin n_fail++; $display("FAIL b2b_pop%0d got %0b/%h want 1/%h", i, res_valid, res_data, exp[i]); end
            step();
        end
        res_ready = 1'b0;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL b2b_drained got %0d want 0", level); end
    endtask

    task automatic test_full_backpressure();
        fill(100, 10);
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level got %0d want 8", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow got %0b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL full_drop_cnt got %0d want 2", drop_cnt); end
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (res_data !== mk(i[0], 100 + i)) begin n_fail++; $display("FAIL full_pop%0d got %h want %h", i, res_data, mk(i[0], 100 + i)); end
            step();
        end
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained got %0b want 0", res_valid); end
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
    endtask

    task automatic test_full_push_pop();
        fill(200, 8);
        valid_output = 1'b1; mode = MODE_TRI; final_output = DW'(999); res_ready = 1'b1;
        step();
        valid_output = 1'b0;
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL fpp_level got %0d want 8", level); end
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL fpp_nodrop got %0b/%0d want 0/0", overflow, drop_cnt); end
        for (int k = 1; k < 8; k++) begin
            n_cmp++; if (res_data !== mk(k[0], 200 + k)) begin n_fail++; $display("FAIL fpp_pop%0d got %h want %h", k, res_data, mk(k[0], 200 + k)); end
            step();
        end
        n_cmp++; if (res_data !== mk(MODE_TRI, 999) || level !== 4'd1) begin n_fail++; $display("FAIL fpp_new got %h/%0d want %h/1", res_data, level, mk(MODE_TRI, 999)); end
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_clear_collision();
        fill(300, 8);
        valid_output = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd5) begin n_fail++; $display("FAIL clr_pre got %0b/%0d want 1/5", overflow, drop_cnt); end
        clear_stats = 1'b1;
        step();
        valid_output = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_collide got %0b/%0d want 1/1", overflow, drop_cnt); end
        step();
        clear_stats = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_alone got %0b/%0d want 0/0", overflow, drop_cnt); end
        valid_output = 1'b1;
        for (int i = 0; i < 260; i++) step();
        valid_output = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL rst_mid_pre got %0d want 8", level); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (level !== 4'd0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flush got %0d/%0b want 0/0", level, res_valid); end
        n_cmp++; if (res_data !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_mid_state got %h/%0b/%0d want 0/0/0", res_data, overflow, drop_cnt); end
    endtask

    task automatic test_sum();
        res_ready = 1'b1; valid_output = 1'b1; mode = MODE_SUMP; final_output = DW'(131071);
`ifdef MAC_COLLECT_SUM_EN
        for (int i = 0; i < 128; i++) step();
        n_cmp++; if (sum_out !== 24'd16777088) begin n_fail++; $display("FAIL sum_128 got %0d want 16777088", sum_out); end
        step();
        step();
        n_cmp++; if (sum_out !== 24'd16777215) begin n_fail++; $display("FAIL sum_saturate got %0d want 16777215", sum_out); end
        clear_stats = 1'b1; final_output = DW'(5);
        step();
        clear_stats = 1'b0;
        n_cmp++; if (sum_out !== 24'd5) begin n_fail++; $display("FAIL sum_clear_push got %0d want 5", sum_out); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (sum_out !== 24'd20) begin n_fail++; $display("FAIL sum_accum got %0d want 20", sum_out); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (sum_out !== 24'd0 || level !== 4'd0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL sum_reset got %0d/%0d/%0b want 0/0/0", sum_out, level, res_valid); end
`else
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (sum_out !== 24'd0) begin n_fail++; $display("FAIL sum_tied got %0d want 0", sum_out); end
`endif
        valid_output = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_tri();
        test_back_to_back();
        test_full_backpressure();
        test_full_push_pop();
        test_clear_collision();
        test_reset_mid();
        test_sum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
